// File: rtl/seg_display_scanner.sv
// seg_display_scanner: time-multiplexed seven-segment driver with
// frame snapshot, blanking, decimal point and leading-zero suppression.
module seg_display_scanner #(
  parameter int DIGITS     = 4,
  parameter int DIV        = 100000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  CLK,
  input  logic                  Reset_n,
  input  logic [4*DIGITS-1:0]   In,
  input  logic [DIGITS-1:0]     Blank,
  input  logic [DIGITS-1:0]     DP,
  input  logic                  LZS,
  output logic [3:0]            Out,
  output logic [7:0]            Seg,
  output logic [DIGITS-1:0]     Bit,
  output logic                  Frame
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIGITS-1:0] BIT_OFF = {DIGITS{ACTIVE_LOW}};
  localparam logic [7:0] SEG_OFF = {8{ACTIVE_LOW}};

  logic [PW-1:0]       pcnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] snap;

  logic                tick;
  logic                last;
  logic [4*DIGITS-1:0] src;
  logic [3:0]          n;
  logic                hz;
  logic                blk;
  logic                dpb;
  logic                dark;
  logic [DIGITS-1:0]   onehot;
  logic [7:0]          seg_al;
  logic [DIGITS-1:0]   bit_ah;
  logic [7:0]          seg_nx;
  logic [DIGITS-1:0]   bit_nx;

  // segments g..a, active-low
  function automatic logic [6:0] dec(input logic [3:0] v);
    logic [6:0] r;
    case (v)
      4'h0: r = 7'h40;
      4'h1: r = 7'h79;
      4'h2: r = 7'h24;
      4'h3: r = 7'h30;
      4'h4: r = 7'h19;
      4'h5: r = 7'h12;
      4'h6: r = 7'h02;
      4'h7: r = 7'h78;
      4'h8: r = 7'h00;
      4'h9: r = 7'h10;
      4'hA: r = 7'h08;
      4'hB: r = 7'h03;
      4'hC: r = 7'h46;
      4'hD: r = 7'h21;
      4'hE: r = 7'h06;
      4'hF: r = 7'h0E;
      default: r = 7'h7F;
    endcase
    return r;
  endfunction

  assign tick = (pcnt == PW'(DIV - 1));
  assign last = (idx == IW'(DIGITS - 1));

  always_comb begin
    src    = (idx == '0) ? In : snap;
    n      = 4'h0;
    hz     = 1'b1;
    blk    = 1'b0;
    dpb    = 1'b0;
    for (int j = 0; j < DIGITS; j++) begin
      if (idx == IW'(j)) begin
        n   = src[4*(DIGITS-j)-1 -: 4];
        blk = Blank[j];
        dpb = DP[j];
      end
      if ((IW'(j) < idx) && (src[4*(DIGITS-j)-1 -: 4] != 4'h0))
        hz = 1'b0;
    end
    dark   = blk | (LZS & (n == 4'h0) & hz & ~last);
    onehot = DIGITS'(1) << idx;
    seg_al = dark ? 8'hFF : {~dpb, dec(n)};
    bit_ah = dark ? '0 : onehot;
    seg_nx = ACTIVE_LOW ? seg_al : ~seg_al;
    bit_nx = ACTIVE_LOW ? ~bit_ah : bit_ah;
  end

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      pcnt  <= '0;
      idx   <= '0;
      snap  <= '0;
      Out   <= 4'h0;
      Seg   <= SEG_OFF;
      Bit   <= BIT_OFF;
      Frame <= 1'b0;
    end else begin
      Frame <= 1'b0;
      if (tick) begin
        pcnt  <= '0;
        idx   <= last ? '0 : idx + IW'(1);
        if (idx == '0)
          snap <= In;
        Out   <= n;
        Seg   <= seg_nx;
        Bit   <= bit_nx;
        Frame <= (idx == '0);
      end else begin
        pcnt <= pcnt + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_seg_display_scanner.sv
// tb_seg_display_scanner: table vectors, hand sequences and a random
// run checked every cycle against a tick-arithmetic reference model.
module tb_seg_display_scanner;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in    = 16'h0;
  logic [3:0]  blank = 4'h0;
  logic [3:0]  dp    = 4'h0;
  logic        lzs   = 1'b0;
  logic [3:0]  out;
  logic [7:0]  seg;
  logic [3:0]  bits;
  logic        frame;

  int errors = 0;
  int checks = 0;

  int          since   = 0;
  logic [15:0] m_snap  = 16'h0;
  logic [3:0]  e_out   = 4'h0;
  logic [3:0]  e_bit   = 4'hF;
  logic [7:0]  e_seg   = 8'hFF;
  logic        e_frame = 1'b0;
  logic [7:0]  tbl [16];

  typedef struct {
    logic [15:0] in;
    logic [3:0]  blank;
    logic [3:0]  dp;
    logic        lzs;
    logic [15:0] outv;
    logic [15:0] bitv;
    logic [31:0] segv;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  seg_display_scanner #(
    .DIGITS(DIGITS), .DIV(DIV), .ACTIVE_LOW(1'b1)
  ) dut (
    .CLK(clk), .Reset_n(rst_n), .In(in), .Blank(blank), .DP(dp),
    .LZS(lzs), .Out(out), .Seg(seg), .Bit(bits), .Frame(frame)
  );

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // expected outputs after the coming edge, from the inputs now applied
  task automatic model_edge();
    int idx;
    int n;
    logic [31:0] src;
    bit supp;
    bit dark;
    if (!rst_n) begin
      since = 0; m_snap = 16'h0; e_out = 4'h0;
      e_bit = 4'hF; e_seg = 8'hFF; e_frame = 1'b0;
    end else begin
      since++;
      e_frame = 1'b0;
      if (since % DIV == 0) begin
        idx  = (since / DIV - 1) % DIGITS;
        src  = (idx == 0) ? {16'h0, in} : {16'h0, m_snap};
        if (idx == 0) m_snap = in;
        n    = int'((src >> (4 * (DIGITS - 1 - idx))) & 32'hF);
        supp = lzs && (n == 0) && ((src >> (4 * (DIGITS - idx))) == 0)
               && (idx != DIGITS - 1);
        dark = blank[idx] || supp;
        e_out   = 4'(n);
        e_frame = (idx == 0);
        if (dark) begin
          e_bit = 4'hF;
          e_seg = 8'hFF;
        end else begin
          e_bit = ~(4'b0001 << idx);
          e_seg = tbl[n];
          if (dp[idx]) e_seg[7] = 1'b0;
        end
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("cycle", {15'b0, out, bits, seg, frame},
        {15'b0, e_out, e_bit, e_seg, e_frame});
  endtask

  task automatic chk_digit(input string nm, input logic [3:0] eo,
                           input logic [3:0] eb, input logic [7:0] es,
                           input logic ef);
    chk(nm, {15'b0, out, bits, seg, frame}, {15'b0, eo, eb, es, ef});
  endtask

  initial begin
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    vecs[0] = '{16'h12AF, 4'h0, 4'h0, 1'b0, 16'h12AF, 16'hEDB7, 32'hF9A4888E};
    vecs[1] = '{16'h0070, 4'h0, 4'h0, 1'b1, 16'h0070, 16'hFFB7, 32'hFFFFF8C0};
    vecs[2] = '{16'h0000, 4'h0, 4'h0, 1'b1, 16'h0000, 16'hFFF7, 32'hFFFFFFC0};
    vecs[3] = '{16'h0007, 4'h0, 4'h0, 1'b0, 16'h0007, 16'hEDB7, 32'hC0C0C0F8};
    vecs[4] = '{16'h8888, 4'b0100, 4'b0010, 1'b0, 16'h8888, 16'hEDF7, 32'h8000FF80};
    vecs[5] = vecs[0];

    rst_n = 1'b0;
    repeat (3) step();
    chk_digit("reset", 4'h0, 4'hF, 8'hFF, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      in = vecs[i].in; blank = vecs[i].blank;
      dp = vecs[i].dp; lzs = vecs[i].lzs;
      for (int d = 0; d < DIGITS; d++) begin
        repeat (DIV) step();
        chk_digit($sformatf("vec%0d_digit%0d", i, d),
                  vecs[i].outv[15-4*d -: 4], vecs[i].bitv[15-4*d -: 4],
                  vecs[i].segv[31-8*d -: 8], d == 0);
      end
    end

    in = 16'h12AF; blank = 4'h0; dp = 4'h0; lzs = 1'b0;
    repeat (DIV) step();
    chk_digit("snap_d0", 4'h1, 4'hE, 8'hF9, 1'b1);
    repeat (DIV) step();
    in = 16'h3456;
    repeat (DIV) step();
    chk_digit("snap_d2", 4'hA, 4'hB, 8'h88, 1'b0);
    repeat (DIV) step();
    chk_digit("snap_d3", 4'hF, 4'h7, 8'h8E, 1'b0);
    repeat (DIV) step();
    chk_digit("snap_next_d0", 4'h3, 4'hE, 8'hB0, 1'b1);
    repeat (DIV) step();
    chk_digit("snap_next_d1", 4'h4, 4'hD, 8'h99, 1'b0);
    repeat (DIV) step();
    chk_digit("snap_next_d2", 4'h5, 4'hB, 8'h92, 1'b0);
    repeat (DIV) step();
    chk_digit("snap_next_d3", 4'h6, 4'h7, 8'h82, 1'b0);

    repeat (3 * DIV) step();
    chk_digit("pre_rst_d2", 4'h5, 4'hB, 8'h92, 1'b0);
    step();
    rst_n = 1'b0;
    step();
    chk_digit("midrst", 4'h0, 4'hF, 8'hFF, 1'b0);
    rst_n = 1'b1;
    repeat (DIV - 1) step();
    chk_digit("midrst_wait", 4'h0, 4'hF, 8'hFF, 1'b0);
    step();
    chk_digit("midrst_d0", 4'h3, 4'hE, 8'hB0, 1'b1);

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) in = 16'($urandom >> $urandom_range(0, 31));
      if ($urandom_range(0, 15) == 0)
        blank = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 15) == 0) dp = 4'($urandom);
      if ($urandom_range(0, 31) == 0) lzs = 1'($urandom);
      rst_n = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_display_scanner.md
# seg_display_scanner

Parametrised multiplexed seven-segment display driver. It time-multiplexes `DIGITS` hex digits onto one shared segment bus, with these features:
- programmable refresh prescaler;
- frame-coherent input snapshot;
- per-digit blanking and decimal point;
- leading-zero suppression;
- built-in hex-to-segment decode.

It sits between the CPU's display value register and the board's anode/cathode pins.

## Interface
Parameters:
- `DIGITS`, default 4, number of multiplexed digits; legal range 1..8.
- `DIV`, default 100000, clock cycles per digit slot; legal range ≥1.
- `ACTIVE_LOW`, default 1. When 1, `Bit` and `Seg` are driven active-low. When 0, they are active-high.

Ports:
- `CLK`, in, 1 bit. Single clock; all logic on its rising edge.
- `Reset_n`, in, 1 bit. Reset is synchronous and active-low.
- `In`, in, 4*DIGITS bits. Display value. Digit k uses nibble `In[4*(DIGITS-k)-1 -: 4]`, so digit 0 is the most significant (leftmost) digit.
- `Blank`, in, DIGITS bits. `Blank[k]`=1 forces digit k dark.
- `DP`, in, DIGITS bits. `DP[k]`=1 lights the decimal point of digit k.
- `LZS`, in, 1 bit. 1 enables leading-zero suppression.
- `Out`, out, 4 bits. Nibble of the currently scanned digit.
- `Seg`, out, 8 bits. Segments in the order {dp,g,f,e,d,c,b,a}.
- `Bit`, out, DIGITS bits. Digit (anode) select; bit k selects digit k.
- `Frame`, out, 1 bit. One-cycle pulse when digit 0 is presented (start of a frame).

## Operation
- **Prescaler:** `pcnt` counts 0..DIV-1 and wraps. `tick` = (`pcnt`==DIV-1). With DIV=1, `tick` is asserted every cycle.
- **Digit index:** `idx` counts 0..DIGITS-1. It advances on `tick` and wraps from DIGITS-1 to 0.
- **Snapshot:** on a `tick` with `idx`==0, `snap`<=`In`, and that digit's outputs are computed from live `In`. On a `tick` with `idx`≠0, outputs are computed from `snap`. Changes on `In` mid-frame therefore never tear a frame.
- **On each `tick`,** for source nibble n = nibble `idx` of the selected value:
  - **Dark condition:** `Blank[idx]`=1, OR a suppression hit. A suppression hit requires all of: `LZS`=1; n==0; all more-significant nibbles of the same source ==0; and `idx`≠DIGITS-1. The least significant digit is never suppressed.
  - **If dark:** `Bit` = all inactive, `Seg` = all off, and `Out` = n.
  - **Else:** `Bit` = one-hot `idx` (polarity per `ACTIVE_LOW`), `Out` = n, `Seg` = decode(n) with dp = `DP[idx]`.
  - `Frame` = 1 iff `idx`==0; otherwise `Frame` = 0.
- **Decode, active-low values** (`ACTIVE_LOW`=0 uses the bitwise inverse; values shown with dp off):

  | n | Seg | n | Seg |
  |---|-----|---|-----|
  | 0 | C0 | 8 | 80 |
  | 1 | F9 | 9 | 90 |
  | 2 | A4 | A | 88 |
  | 3 | B0 | b | 83 |
  | 4 | 99 | C | C6 |
  | 5 | 92 | d | A1 |
  | 6 | 82 | E | 86 |
  | 7 | F8 | F | 8E |

  A lit dp clears `Seg[7]` in active-low mode.
- **Reset** (`Reset_n`=0 at a rising edge): `pcnt`=0, `idx`=0, `snap`=0, `Out`=0, `Bit`=all inactive, `Seg`=all off (8'hFF when `ACTIVE_LOW`=1), `Frame`=0. Reset overrides a coincident `tick`.

## Timing
- All outputs are registered and change only in the cycle after a `tick` edge. They hold for DIV cycles.
- After reset release, the first `tick` occurs on the DIV-th rising edge. Digit 0 is therefore visible DIV cycles after release.
- Frame period = DIGITS*DIV cycles. `Frame` is high for exactly 1 cycle per frame.
- `Blank`, `DP` and `LZS` are sampled live on each `tick`; they are not snapshotted.
- A mid-frame reset restarts the sequence at digit 0 with a fresh snapshot on the first `tick`.
- DIGITS=1: `idx` is always 0, so every `tick` snapshots and pulses `Frame`.

## Test plan
All scenarios use DIGITS=4, DIV=4, ACTIVE_LOW=1.
- **Reset:** hold `Reset_n`=0 for 3 cycles → `Bit`=4'b1111, `Seg`=8'hFF, `Out`=0, `Frame`=0.
- **Scan order:** after release with `In`=16'h12AF, `Blank`=`DP`=0, `LZS`=0, successive ticks every 4 cycles give:
  - (`Bit`,`Out`,`Seg`) = (1110,1,F9), (1101,2,A4), (1011,A,88), (0111,F,8E);
  - then wrap to (1110,1,F9) with `Frame`=1 only on the digit-0 slots.
- **Snapshot:** change `In` to 16'h3456 while digit 1 is shown → digits 2 and 3 still show A and F; the next frame shows 3,4,5,6.
- **LZS:**
  - `In`=16'h0070, `LZS`=1 → digits 0 and 1 give `Bit`=1111 and `Seg`=FF; digit 2 shows F8 and digit 3 shows C0.
  - `In`=16'h0000 → only digit 3 is lit (C0).
  - `In`=16'h0007 with `LZS`=0 → all digits lit.
- **Blank/DP:** `In`=16'h8888, `DP`=4'b0010, `Blank`=4'b0100 → digit 1 `Seg`=8'h00; digit 2 gives `Bit`=1111 and `Seg`=FF; digits 0 and 3 give `Seg`=80.
- **Mid-frame reset:** assert `Reset_n`=0 for 1 cycle during digit 2 → outputs return to their reset values next cycle; digit 0 reappears exactly 4 cycles after release, with `Frame`=1.
